progmem_arbiter: RTL and testbench

PROGMEM_ARBITER -- requirements
Module: progmem_arbiter

---
 rtl/progmem_pkg.sv | 14 +
 rtl/progmem_arbiter_rr_arb2.sv | 18 +
 rtl/progmem_arbiter.sv | 126 ++++++++++++
 tb/tb_progmem_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/progmem_pkg.sv
// Shared definitions for the two-master program-memory arbiter.
package progmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } pm_state_e;

  localparam int         PM_ADDR_W = 15;
  localparam int         PM_DATA_W = 32;
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/progmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on contention the master not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/progmem_arbiter.sv
// Arbitrates two masters onto one program-memory slave, one single-word
// transfer per grant, with a forced idle cycle between transfers.
module progmem_arbiter
  import progmem_pkg::*;
#(
  parameter int ADDR_W = PM_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic [ADDR_W-1:0]    m0_address,
  input  logic                 m0_read,
  input  logic                 m0_write,
  input  logic [3:0]           m0_byteenable,
  input  logic [PM_DATA_W-1:0] m0_writedata,
  output logic [PM_DATA_W-1:0] m0_readdata,
  output logic [1:0]           m0_response,
  output logic                 m0_waitrequest,

  input  logic [ADDR_W-1:0]    m1_address,
  input  logic                 m1_read,
  input  logic                 m1_write,
  input  logic [3:0]           m1_byteenable,
  input  logic [PM_DATA_W-1:0] m1_writedata,
  output logic [PM_DATA_W-1:0] m1_readdata,
  output logic [1:0]           m1_response,
  output logic                 m1_waitrequest,

  output logic [ADDR_W-1:0]    s_address,
  output logic                 s_read,
  output logic                 s_write,
  output logic [3:0]           s_byteenable,
  output logic [PM_DATA_W-1:0] s_writedata,
  input  logic [PM_DATA_W-1:0] s_readdata,
  input  logic [1:0]           s_response,
  input  logic                 s_waitrequest,

  output logic [1:0]           grant_o
);

  pm_state_e  state_q;
  logic       last_grant_q;
  logic       req0, req1;
  logic       own0, own1;
  logic       accept;
  logic [1:0] pick;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Ownership is masked while reset is asserted so the slave sees no command.
  assign own0 = rst_n & (state_q == OWN0);
  assign own1 = rst_n & (state_q == OWN1);

  rr_arb2 u_rr (
    .req  ({req1, req0}),
    .last (last_grant_q),
    .gnt  (pick)
  );

  always_comb begin
    s_address    = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_byteenable = '0;
    s_writedata  = '0;
    if (own0) begin
      s_address    = m0_address;
      s_read       = m0_read;
      s_write      = m0_write;
      s_byteenable = m0_byteenable;
      s_writedata  = m0_writedata;
    end else if (own1) begin
      s_address    = m1_address;
      s_read       = m1_read;
      s_write      = m1_write;
      s_byteenable = m1_byteenable;
      s_writedata  = m1_writedata;
    end
  end

  assign accept = (s_read | s_write) & ~s_waitrequest;

  assign m0_waitrequest = req0 & (own0 ? s_waitrequest : 1'b1);
  assign m1_waitrequest = req1 & (own1 ? s_waitrequest : 1'b1);

  // Return data is broadcast; each master only samples in its own accept cycle.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign m0_response = s_response;
  assign m1_response = s_response;

  assign grant_o = {own1, own0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick[0])      state_q <= OWN0;
          else if (pick[1]) state_q <= OWN1;
        end
        OWN0: begin
          if (accept) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
          end else if (!req0) begin
            state_q <= IDLE;
          end
        end
        OWN1: begin
          if (accept) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
          end else if (!req1) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_progmem_arbiter.sv
// Directed bench for progmem_arbiter with hand-computed expectations.
module tb_progmem_arbiter;
  import progmem_pkg::*;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic          m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [3:0]    m0_byteenable, m1_byteenable, s_byteenable;
  logic [31:0]   m0_writedata, m1_writedata, s_writedata;
  logic [31:0]   m0_readdata, m1_readdata, s_readdata;
  logic [1:0]    m0_response, m1_response, s_response;
  logic          m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [1:0]    grant_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  progmem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_readdata(m0_readdata), .m0_response(m0_response), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_readdata(m1_readdata), .m1_response(m1_response), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .s_response(s_response), .s_waitrequest(s_waitrequest),
    .grant_o(grant_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_address = '0; m0_read = 0; m0_write = 0; m0_byteenable = '0; m0_writedata = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_byteenable = '0; m1_writedata = '0;
    s_readdata = '0; s_response = RESP_OKAY; s_waitrequest = 1'b0;

    // reset state
    cyc(); cyc(); mid();
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_sread", s_read, 1'b0);
    chk("rst_m0wait_idle", m0_waitrequest, 1'b0);
    cyc(); m0_read = 1; mid();
    chk("rst_m0wait_req", m0_waitrequest, 1'b1);
    chk("rst_sread_req", s_read, 1'b0);
    cyc(); m0_read = 0; rst_n = 1'b1;

    // single read with 4 wait cycles
    m0_address = 15'h0010; m0_read = 1; s_waitrequest = 1; mid();
    chk("t1_idle_sread", s_read, 1'b0);
    chk("t1_idle_m0wait", m0_waitrequest, 1'b1);
    cyc(); mid();
    chk("t1_sread", s_read, 1'b1);
    chk("t1_saddr", s_address, 15'h0010);
    chk("t1_grant", grant_o, 2'b01);
    chk("t1_m0wait", m0_waitrequest, 1'b1);
    chk("t1_m1wait", m1_waitrequest, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); mid();
      chk("t1_wait_cyc", m0_waitrequest, 1'b1);
    end
    cyc(); s_waitrequest = 0; s_readdata = 32'hDEADBEEF; s_response = 2'b01; mid();
    chk("t1_rdata", m0_readdata, 32'hDEADBEEF);
    chk("t1_m1rdata_bcast", m1_readdata, 32'hDEADBEEF);
    chk("t1_resp", m0_response, 2'b01);
    chk("t1_m0wait_acc", m0_waitrequest, 1'b0);
    chk("t1_m1wait_acc", m1_waitrequest, 1'b0);
    cyc(); m0_read = 0; s_response = RESP_OKAY; mid();
    chk("t1_post_grant", grant_o, 2'b00);
    chk("t1_post_sread", s_read, 1'b0);

    // contention straight after reset: m0 first
    cyc(); rst_n = 0;
    cyc(); rst_n = 1; m0_read = 1; m1_read = 1; s_waitrequest = 0; mid();
    chk("t2_g0", grant_o, 2'b00);
    cyc(); mid();
    chk("t2_g1", grant_o, 2'b01);
    cyc(); m0_read = 0; mid();
    chk("t2_g2", grant_o, 2'b00);
    chk("t2_m1wait", m1_waitrequest, 1'b1);
    cyc(); mid();
    chk("t2_g3", grant_o, 2'b10);
    cyc(); m1_read = 0; mid();
    chk("t2_g4", grant_o, 2'b00);

    // continuous contention: strict alternation with idle gaps
    cyc(); m0_read = 1; m1_read = 1; mid();
    chk("t3_start", grant_o, 2'b00);
    for (int k = 0; k < 6; k++) begin
      cyc(); mid();
      chk("t3_own", grant_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
      if (k == 5) begin m0_read = 0; m1_read = 0; end
      mid();
      chk("t3_gap_grant", grant_o, 2'b00);
      chk("t3_gap_sread", s_read, 1'b0);
    end

    // m1 write while m0 read is held off
    cyc(); m1_write = 1; m1_address = 15'h0004; m1_byteenable = 4'b0011;
    m1_writedata = 32'h12345678; s_waitrequest = 1; mid();
    chk("t4_idle", grant_o, 2'b00);
    cyc(); m0_read = 1; m0_address = 15'h0020; mid();
    chk("t4_swrite", s_write, 1'b1);
    chk("t4_sread", s_read, 1'b0);
    chk("t4_saddr", s_address, 15'h0004);
    chk("t4_sbe", s_byteenable, 4'b0011);
    chk("t4_swd", s_writedata, 32'h12345678);
    chk("t4_m0wait", m0_waitrequest, 1'b1);
    cyc(); s_waitrequest = 0; mid();
    chk("t4_m1wait_acc", m1_waitrequest, 1'b0);
    chk("t4_m0wait_acc", m0_waitrequest, 1'b1);
    cyc(); m1_write = 0; mid();
    chk("t4_gap_swrite", s_write, 1'b0);
    chk("t4_gap_m0wait", m0_waitrequest, 1'b1);
    cyc(); mid();
    chk("t4_m0_grant", grant_o, 2'b01);
    chk("t4_m0_saddr", s_address, 15'h0020);
    chk("t4_m0_swrite", s_write, 1'b0);
    chk("t4_m0wait_own", m0_waitrequest, 1'b0);
    cyc(); m0_read = 0; mid();
    chk("t4_end", grant_o, 2'b00);

    // reset in the middle of an OWN0 wait
    cyc(); m0_read = 1; s_waitrequest = 1; mid();
    chk("t5_idle", grant_o, 2'b00);
    cyc(); mid();
    chk("t5_own0", grant_o, 2'b01);
    cyc(); rst_n = 0; mid();
    chk("t5_rst_grant", grant_o, 2'b00);
    chk("t5_rst_sread", s_read, 1'b0);
    chk("t5_rst_m0wait", m0_waitrequest, 1'b1);
    cyc(); rst_n = 1; m0_read = 0; mid();
    chk("t5_after_grant", grant_o, 2'b00);
    chk("t5_after_sread", s_read, 1'b0);
    cyc(); m1_read = 1; m0_read = 1; s_waitrequest = 0; mid();
    chk("t5_cont_idle", grant_o, 2'b00);
    cyc(); mid();
    chk("t5_m0_wins", grant_o, 2'b01);
    cyc(); m0_read = 0; mid();
    chk("t5_gap", grant_o, 2'b00);
    cyc(); mid();
    chk("t5_m1", grant_o, 2'b10);
    cyc(); m1_read = 0; mid();
    chk("t5_end", grant_o, 2'b00);

    // owner abandons its request before accept
    cyc(); m0_read = 1; s_waitrequest = 1; mid();
    chk("t6_idle", grant_o, 2'b00);
    cyc(); mid();
    chk("t6_own0", grant_o, 2'b01);
    chk("t6_sread", s_read, 1'b1);
    cyc(); m0_read = 0; mid();
    chk("t6_drop_sread", s_read, 1'b0);
    chk("t6_drop_m0wait", m0_waitrequest, 1'b0);
    cyc(); mid();
    chk("t6_back_idle", grant_o, 2'b00);
    cyc(); m0_read = 1; m1_read = 1; s_waitrequest = 0; mid();
    chk("t6_cont_idle", grant_o, 2'b00);
    cyc(); mid();
    chk("t6_last_kept", grant_o, 2'b01);
    cyc(); m0_read = 0; mid();
    cyc(); mid();
    chk("t6_m1", grant_o, 2'b10);
    cyc(); m1_read = 0; mid();
    chk("t6_end", grant_o, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
